// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : AES-128 S-box, Rcon table, round helper functions, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Byte b of the S-box lives at bits [2047-8*b -: 8].
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [87:0] c_RCON = 88'h00_01_02_04_08_10_20_40_80_1b_36;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        if (n > 4'd10) return 8'h00;
        return c_RCON[87 - 8 * int'(n) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
        return r;
    endfunction

    // FIPS byte i = row i%4, column i/4, stored MSB-first.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                r[127 - 8*(rw + 4*c) -: 8] = s[127 - 8*(rw + 4*((c + rw) % 4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127 - 32*c -: 32];
            r[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_iter_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_iter_engine_if
// Description : Block-in / block-out valid-ready streams of the AES engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_iter_engine_if;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
    modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface
`default_nettype wire

// File: rtl/aes_round.sv
`default_nettype none
// ============================================================================
// Module      : aes_round
// Description : One combinational AES-128 round with on-the-fly key expansion.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    input  logic         is_final_i,
    output logic [127:0] state_o,
    output logic [127:0] key_o
);
    logic [127:0] w_sr;

    assign key_o   = key_step(key_i, rcon_i);
    assign w_sr    = shift_rows(sub_bytes(state_i));
    assign state_o = (is_final_i ? w_sr : mix_columns(w_sr)) ^ key_o;
endmodule
`default_nettype wire

// File: rtl/aes_iter_engine.sv
`default_nettype none
// ============================================================================
// Module      : aes_iter_engine
// Description : Iterative AES-128 encryptor, ECB or CTR, ROUNDS_PER_CYCLE rounds/clk.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_iter_engine
    import aes_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int CTR_MODE         = 0,
    parameter int CTR_WIDTH        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable_i,
    input  logic [127:0]  key_i,
    input  logic          key_load_i,
    input  logic [127:0]  ctr_i,
    input  logic          ctr_load_i,
    aes_iter_engine_if.slave s_if
);
    localparam int N     = (ROUNDS_PER_CYCLE > 0) ? 10 / ROUNDS_PER_CYCLE : 1;
    localparam int RND_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (!(ROUNDS_PER_CYCLE inside {1, 2, 5, 10})) begin : g_bad_rpc
            $error("aes_iter_engine: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
        end
        if (CTR_WIDTH < 1 || CTR_WIDTH > 128) begin : g_bad_ctr_width
            $error("aes_iter_engine: CTR_WIDTH must be in 1..128");
        end
    endgenerate

    state_e             state_q;
    logic [RND_W-1:0]   rnd_q;
    logic [127:0]       aes_q, rk_q, data_q, key_q, out_data_q;
    logic               out_valid_q;

    logic               w_idle, w_ready, w_accept, w_last;
    logic [127:0]       w_key_sel, w_ctr_sel, w_blk, w_res;
    logic [3:0]         w_base;
    logic [ROUNDS_PER_CYCLE:0][127:0] w_st, w_rk;

    assign w_idle    = (state_q == IDLE);
    assign w_ready   = w_idle && enable_i && (!out_valid_q || s_if.out_ready);
    assign w_accept  = s_if.in_valid && w_ready;
    assign w_last    = (rnd_q == RND_W'(N - 1));
    assign w_key_sel = (key_load_i && w_idle) ? key_i : key_q;
    assign w_blk     = (CTR_MODE != 0) ? w_ctr_sel : s_if.in_data;

    generate
        if (CTR_MODE != 0) begin : g_ctr
            localparam logic [127:0] c_CTR_MASK =
                (CTR_WIDTH >= 128) ? {128{1'b1}} : ((128'd1 << CTR_WIDTH) - 128'd1);
            logic [127:0] ctr_q;

            assign w_ctr_sel = (ctr_load_i && w_idle) ? ctr_i : ctr_q;

            // Only the low CTR_WIDTH bits count; the carry never reaches the upper field.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ctr_q <= '0;
                end else if (w_accept) begin
                    ctr_q <= (w_ctr_sel & ~c_CTR_MASK) | ((w_ctr_sel + 128'd1) & c_CTR_MASK);
                end else if (ctr_load_i && w_idle) begin
                    ctr_q <= ctr_i;
                end
            end
        end else begin : g_no_ctr
            logic w_unused_ctr;
            assign w_unused_ctr = ^{ctr_i, ctr_load_i};
            assign w_ctr_sel    = '0;
        end
    endgenerate

    assign w_base = 4'(rnd_q) * 4'(ROUNDS_PER_CYCLE);
    assign w_st[0] = aes_q;
    assign w_rk[0] = rk_q;

    generate
        for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
            logic [3:0] w_num;
            assign w_num = w_base + 4'(j + 1);
            aes_round u_round (
                .state_i    (w_st[j]),
                .key_i      (w_rk[j]),
                .rcon_i     (rcon(w_num)),
                .is_final_i (w_num == 4'd10),
                .state_o    (w_st[j+1]),
                .key_o      (w_rk[j+1])
            );
        end
    endgenerate

    assign w_res = w_st[ROUNDS_PER_CYCLE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rnd_q       <= '0;
            aes_q       <= '0;
            rk_q        <= '0;
            data_q      <= '0;
            key_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (key_load_i && w_idle) key_q <= key_i;
            if (out_valid_q && s_if.out_ready) out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        aes_q   <= w_blk ^ w_key_sel;
                        rk_q    <= w_key_sel;
                        data_q  <= s_if.in_data;
                        rnd_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    aes_q <= w_res;
                    rk_q  <= w_rk[ROUNDS_PER_CYCLE];
                    if (w_last) begin
                        out_data_q  <= (CTR_MODE != 0) ? (w_res ^ data_q) : w_res;
                        out_valid_q <= 1'b1;
                        rnd_q       <= '0;
                        state_q     <= IDLE;
                    end else begin
                        rnd_q <= rnd_q + RND_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_if.in_ready  = w_ready;
    assign s_if.out_data  = out_data_q;
    assign s_if.out_valid = out_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_aes_iter_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_iter_engine
// Description : Self-checking bench: four ECB engines (1/2/5/10 rounds/clk), one CTR engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_iter_engine;
    localparam int NI = 5;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CTR0 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C1 = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2 = 128'h9806f66b7970fdff8617187bb9fffdff;

    logic clk = 1'b0;
    logic rst;
    logic         en    [NI];
    logic [127:0] key   [NI];
    logic         kload [NI];
    logic [127:0] ctr   [NI];
    logic         cload [NI];
    logic [127:0] idat  [NI];
    logic         ival  [NI];
    logic         ordy  [NI];
    wire          irdy  [NI];
    wire  [127:0] odat  [NI];
    wire          oval  [NI];

    logic [127:0] km [NI];
    logic [127:0] cm;
    logic [7:0]   sb [256];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int RPC = (k == 1) ? 2 : (k == 2) ? 5 : (k == 3) ? 10 : (k == 4) ? 2 : 1;
        aes_iter_engine_if u_if ();
        assign u_if.in_data   = idat[k];
        assign u_if.in_valid  = ival[k];
        assign u_if.out_ready = ordy[k];
        assign irdy[k] = u_if.in_ready;
        assign odat[k] = u_if.out_data;
        assign oval[k] = u_if.out_valid;
        aes_iter_engine #(.ROUNDS_PER_CYCLE(RPC), .CTR_MODE((k == 4) ? 1 : 0), .CTR_WIDTH(32)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .enable_i   (en[k]),
            .key_i      (key[k]),
            .key_load_i (kload[k]),
            .ctr_i      (ctr[k]),
            .ctr_load_i (cload[k]),
            .s_if       (u_if)
        );
    end

    // ---------------- reference model (byte-level FIPS-197) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            x = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[v] = x;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] kin, input logic [127:0] pt);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] tmp;
        logic [7:0]  rc, a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 4; i++) w[i] = kin[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rd < 10) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31 - 8*(i%4) -: 8];
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic logic [127:0] ctr_inc(input logic [127:0] c);
        return {c[127:32], c[31:0] + 32'd1};
    endfunction

    function automatic int nlat(input int k);
        case (k)
            0: return 10;
            1: return 5;
            2: return 2;
            3: return 1;
            default: return 5;
        endcase
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input int k, input logic [127:0] kv);
        key[k] = kv; kload[k] = 1'b1; km[k] = kv;
        tick();
        kload[k] = 1'b0;
    endtask

    task automatic run_block(input int k, input logic [127:0] d,
                             output logic [127:0] got, output int lat, output bit to);
        int n = 0;
        got = '0; lat = 0; to = 1'b0;
        idat[k] = d; ival[k] = 1'b1;
        #1;
        while (!irdy[k] && n < 100) begin tick(); n++; end
        if (!irdy[k]) begin to = 1'b1; ival[k] = 1'b0; return; end
        tick();
        ival[k] = 1'b0; kload[k] = 1'b0; cload[k] = 1'b0;
        while (!oval[k] && lat < 40) begin tick(); lat++; end
        to  = !oval[k];
        got = odat[k];
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (oval[k] !== 1'b0 || odat[k] !== 128'h0 || irdy[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset k=%0d out_valid=%b out_data=%h in_ready=%b required 0/0/0",
                         k, oval[k], odat[k], irdy[k]);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < NI; k++) en[k] = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (irdy[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready k=%0d in_ready=%b required 1", k, irdy[k]);
            end
        end
    endtask

    task automatic test_fips_b();
        logic [127:0] got; int lat; bit to;
        for (int k = 0; k < 4; k++) begin
            load_key(k, KB);
            run_block(k, PB, got, lat, to);
            n_checks++;
            if (to || got !== CB || lat != nlat(k)) begin
                n_fail++;
                $display("FAIL fips_b k=%0d got=%h lat=%0d timeout=%0d required %h lat=%0d",
                         k, got, lat, to, CB, nlat(k));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] got, d; int lat; bit to;
        load_key(0, KC);
        ordy[0] = 1'b0;
        run_block(0, PC, got, lat, to);
        n_checks++;
        if (to || got !== CC) begin
            n_fail++;
            $display("FAIL bp_data got=%h timeout=%0d required %h", got, to, CC);
        end
        d = rnd128();
        idat[0] = d; ival[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (odat[0] !== CC || oval[0] !== 1'b1 || irdy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d out_data=%h out_valid=%b in_ready=%b required %h/1/0",
                         i, odat[0], oval[0], irdy[0], CC);
            end
        end
        ordy[0] = 1'b1;
        #1;
        n_checks++;
        if (irdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain_ready in_ready=%b required 1", irdy[0]);
        end
        run_block(0, d, got, lat, to);
        n_checks++;
        if (to || got !== aes_ref(KC, d)) begin
            n_fail++;
            $display("FAIL bp_next got=%h required %h", got, aes_ref(KC, d));
        end
    endtask

    task automatic test_ctr_back_to_back();
        logic [127:0] g1, g2; int l1, l2; bit t1, t2;
        key[4] = KB; kload[4] = 1'b1; km[4] = KB;
        ctr[4] = CTR0; cload[4] = 1'b1; cm = CTR0;
        tick();
        kload[4] = 1'b0; cload[4] = 1'b0;
        run_block(4, P1, g1, l1, t1);
        run_block(4, P2, g2, l2, t2);
        cm = ctr_inc(ctr_inc(cm));
        n_checks++;
        if (t1 || g1 !== C1 || l1 != 5) begin
            n_fail++;
            $display("FAIL ctr_blk1 got=%h lat=%0d required %h lat=5", g1, l1, C1);
        end
        n_checks++;
        if (t2 || g2 !== C2 || l2 != 5) begin
            n_fail++;
            $display("FAIL ctr_blk2 got=%h lat=%0d required %h lat=5", g2, l2, C2);
        end
    endtask

    task automatic test_ctr_wrap();
        logic [127:0] got, d, c; int lat; bit to;
        c = 128'h0000_0000_0000_0000_0000_0001_ffff_ffff;
        ctr[4] = c; cload[4] = 1'b1; cm = c;
        for (int i = 0; i < 2; i++) begin
            d = rnd128();
            run_block(4, d, got, lat, to);
            n_checks++;
            if (to || got !== (d ^ aes_ref(km[4], cm))) begin
                n_fail++;
                $display("FAIL ctr_wrap blk=%0d got=%h required %h", i, got, d ^ aes_ref(km[4], cm));
            end
            cm = ctr_inc(cm);
        end
    endtask

    task automatic test_key_load();
        logic [127:0] ka, kb, d1, d2, d3, got; int lat, n; bit to;
        ka = rnd128(); kb = rnd128(); d1 = rnd128(); d2 = rnd128(); d3 = rnd128();
        load_key(0, ka);
        idat[0] = d1; ival[0] = 1'b1; n = 0;
        #1;
        while (!irdy[0] && n < 50) begin tick(); n++; end
        tick();
        ival[0] = 1'b0;
        tick();
        key[0] = kb; kload[0] = 1'b1;
        tick();
        kload[0] = 1'b0;
        lat = 0;
        while (!oval[0] && lat < 40) begin tick(); lat++; end
        n_checks++;
        if (!oval[0] || odat[0] !== aes_ref(ka, d1)) begin
            n_fail++;
            $display("FAIL key_busy_blk got=%h required %h", odat[0], aes_ref(ka, d1));
        end
        run_block(0, d2, got, lat, to);
        n_checks++;
        if (to || got !== aes_ref(ka, d2)) begin
            n_fail++;
            $display("FAIL key_busy_next got=%h required %h", got, aes_ref(ka, d2));
        end
        key[0] = kb; kload[0] = 1'b1; km[0] = kb;
        run_block(0, d3, got, lat, to);
        n_checks++;
        if (to || got !== aes_ref(kb, d3)) begin
            n_fail++;
            $display("FAIL key_coincident got=%h required %h", got, aes_ref(kb, d3));
        end
    endtask

    task automatic test_enable();
        logic [127:0] kv, d1, d2, got; int lat, n; bit to;
        kv = rnd128(); d1 = rnd128(); d2 = rnd128();
        load_key(1, kv);
        idat[1] = d1; ival[1] = 1'b1; n = 0;
        #1;
        while (!irdy[1] && n < 50) begin tick(); n++; end
        tick();
        en[1] = 1'b0; idat[1] = d2;
        lat = 0;
        while (!oval[1] && lat < 40) begin tick(); lat++; end
        n_checks++;
        if (!oval[1] || odat[1] !== aes_ref(kv, d1) || lat != 5) begin
            n_fail++;
            $display("FAIL enable_inflight got=%h lat=%0d required %h lat=5", odat[1], lat, aes_ref(kv, d1));
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (irdy[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_block cyc=%0d in_ready=%b required 0", i, irdy[1]);
            end
        end
        n_checks++;
        if (oval[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_noaccept out_valid=%b required 0", oval[1]);
        end
        en[1] = 1'b1;
        run_block(1, d2, got, lat, to);
        n_checks++;
        if (to || got !== aes_ref(kv, d2)) begin
            n_fail++;
            $display("FAIL enable_resume got=%h required %h", got, aes_ref(kv, d2));
        end
    endtask

    task automatic test_random();
        logic [127:0] d, exp, got; int k, lat; bit to;
        for (int it = 0; it < 16; it++) begin
            k = $urandom_range(0, NI - 1);
            d = rnd128();
            if ($urandom_range(0, 1) == 1) begin
                key[k] = rnd128(); kload[k] = 1'b1; km[k] = key[k];
            end
            if (k == 4 && $urandom_range(0, 1) == 1) begin
                ctr[4] = rnd128(); cload[4] = 1'b1; cm = ctr[4];
            end
            exp = (k == 4) ? (d ^ aes_ref(km[4], cm)) : aes_ref(km[k], d);
            if (k == 4) cm = ctr_inc(cm);
            run_block(k, d, got, lat, to);
            n_checks++;
            if (to || got !== exp || lat != nlat(k)) begin
                n_fail++;
                $display("FAIL random it=%0d k=%0d got=%h lat=%0d required %h lat=%0d",
                         it, k, got, lat, exp, nlat(k));
            end
        end
    endtask

    task automatic test_reset_busy();
        logic [127:0] got; int lat, n; bit to;
        load_key(0, KB);
        run_block(0, PB, got, lat, to);
        idat[0] = rnd128(); ival[0] = 1'b1; n = 0;
        #1;
        while (!irdy[0] && n < 50) begin tick(); n++; end
        tick();
        ival[0] = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (oval[0] !== 1'b0 || odat[0] !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_busy out_valid=%b out_data=%h required 0/0", oval[0], odat[0]);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < NI; k++) km[k] = '0;
        cm = '0;
        run_block(0, PB, got, lat, to);
        n_checks++;
        if (to || got !== aes_ref(128'h0, PB)) begin
            n_fail++;
            $display("FAIL reset_key_cleared got=%h required %h", got, aes_ref(128'h0, PB));
        end
        load_key(0, KB);
        run_block(0, PB, got, lat, to);
        n_checks++;
        if (to || got !== CB) begin
            n_fail++;
            $display("FAIL reset_reload got=%h required %h", got, CB);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            en[k] = 1'b0; key[k] = '0; kload[k] = 1'b0; ctr[k] = '0; cload[k] = 1'b0;
            idat[k] = '0; ival[k] = 1'b0; ordy[k] = 1'b1; km[k] = '0;
        end
        cm = '0;
        build_sbox();
        test_reset();
        test_fips_b();
        test_backpressure();
        test_ctr_back_to_back();
        test_ctr_wrap();
        test_key_load();
        test_enable();
        test_random();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
